// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Optional MULDIV_FAST_MUL_EN: single-cycle 33x33 multiplier for all four multiply ops.
module muldiv_unit (
  input  logic        clk,
  input  logic        arst,
  input  logic        inValid,
  output logic        inReady,
  input  logic [2:0]  funct3,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [4:0]  rdAddr,
  input  logic        flush,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] result,
  output logic [4:0]  outRdAddr
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

  stateT       state, nextState;
  logic [2:0]  op;
  logic [63:0] acc;
  logic [31:0] oper;
  logic        negRes;
  logic [5:0]  count;

  // Request decode, only meaningful in the accept cycle
  logic        accept, isDiv, aSigned, bSigned, signA, signB;
  logic [31:0] magA, magB;
  logic        divByZero, divOverflow, special, skipCalc;
  logic [31:0] specialResult;

  assign accept  = inValid & (state == IDLE) & ~flush;
  assign isDiv   = funct3[2];
  assign aSigned = isDiv ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign bSigned = isDiv ? ~funct3[0] : ~funct3[1];
  assign signA   = aSigned & operandA[31];
  assign signB   = bSigned & operandB[31];
  assign magA    = signA ? -operandA : operandA;
  assign magB    = signB ? -operandB : operandB;

  assign divByZero     = isDiv & (operandB == 32'd0);
  assign divOverflow   = isDiv & ~funct3[0] & (operandA == 32'h8000_0000) & (operandB == 32'hFFFF_FFFF);
  assign special       = divByZero | divOverflow;
  assign specialResult = divByZero ? (funct3[1] ? operandA : 32'hFFFF_FFFF)
                                   : (funct3[1] ? 32'd0 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
  logic [32:0] fastA, fastB;
  logic [65:0] fastProd;
  logic [31:0] fastResult;

  assign fastA      = {signA, operandA};
  assign fastB      = {signB, operandB};
  assign fastProd   = $signed(fastA) * $signed(fastB);
  assign fastResult = (funct3[1:0] == 2'b00) ? fastProd[31:0] : fastProd[63:32];
  assign skipCalc   = special | ~isDiv;
`else
  assign skipCalc   = special;
`endif

  // One iteration step: acc holds {partial hi, multiplier} or {remainder, dividend/quotient}
  logic [32:0] mulSum, divShift, divTrial;
  logic        divFits;
  logic [63:0] mulNext, divNext, accNext;
  logic [63:0] prodSigned;
  logic [31:0] divVal, divSigned, finalResult;

  assign mulSum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, oper} : 33'd0);
  assign mulNext  = {mulSum, acc[31:1]};
  assign divShift = {acc[63:32], acc[31]};
  assign divTrial = divShift - {1'b0, oper};
  assign divFits  = divShift >= {1'b0, oper};
  assign divNext  = divFits ? {divTrial[31:0], acc[30:0], 1'b1}
                            : {divShift[31:0], acc[30:0], 1'b0};
  assign accNext  = op[2] ? divNext : mulNext;

  assign prodSigned  = negRes ? -accNext : accNext;
  assign divVal      = op[1] ? accNext[63:32] : accNext[31:0];
  assign divSigned   = negRes ? -divVal : divVal;
  assign finalResult = op[2] ? divSigned
                             : ((op[1:0] == 2'b00) ? prodSigned[31:0] : prodSigned[63:32]);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = skipCalc ? DONE : CALC;
      CALC:    if (count == 6'd31) nextState = DONE;
      DONE:    if (outReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (flush) nextState = IDLE;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      op        <= 3'd0;
      acc       <= 64'd0;
      oper      <= 32'd0;
      negRes    <= 1'b0;
      count     <= 6'd0;
      result    <= 32'd0;
      outRdAddr <= 5'd0;
    end else if (accept) begin
      op        <= funct3;
      acc       <= {32'd0, isDiv ? magA : magB};
      oper      <= isDiv ? magB : magA;
      negRes    <= (isDiv & funct3[1]) ? signA : (signA ^ signB);
      count     <= 6'd0;
      outRdAddr <= rdAddr;
      if (special) result <= specialResult;
`ifdef MULDIV_FAST_MUL_EN
      else if (!isDiv) result <= fastResult;
`endif
    end else if (state == CALC) begin
      acc <= accNext;
      if (count == 6'd31) begin
        count  <= 6'd0;
        result <= finalResult;
      end else begin
        count <= count + 6'd1;
      end
    end
  end

  assign inReady  = (state == IDLE);
  assign outValid = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        arst;
  logic        inValid, inReady;
  logic [2:0]  funct3;
  logic [31:0] operandA, operandB;
  logic [4:0]  rdAddr;
  logic        flush;
  logic        outValid, outReady;
  logic [31:0] result;
  logic [4:0]  outRdAddr;

  int checks = 0;
  int failures = 0;
  logic [36:0] expQ[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  muldiv_unit dut (
    .clk(clk), .arst(arst), .inValid(inValid), .inReady(inReady), .funct3(funct3),
    .operandA(operandA), .operandB(operandB), .rdAddr(rdAddr), .flush(flush),
    .outValid(outValid), .outReady(outReady), .result(result), .outRdAddr(outRdAddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake
  always @(negedge clk) begin
    if (!arst && outValid === 1'b1 && outReady === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got 0x%0h rd %0d expected no result", result, outRdAddr);
      end else begin
        logic [36:0] e;
        e = expQ.pop_front();
        check("result", {32'd0, result}, {32'd0, e[36:5]});
        check("outRdAddr", {59'd0, outRdAddr}, {59'd0, e[4:0]});
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit push);
    int n = 0;
    while (!inReady && n < 100) begin @(posedge clk); #1; n++; end
    check("issue_ready", {63'd0, inReady}, 64'd1);
    inValid = 1'b1; funct3 = f; operandA = a; operandB = b; rdAddr = rd;
    @(posedge clk);
    if (push) expQ.push_back({exp, rd});
    #1;
    inValid = 1'b0;
    funct3 = 3'($urandom); operandA = $urandom; operandB = $urandom; rdAddr = 5'($urandom);
  endtask

  task automatic waitDone(input string name, input int expLat);
    int lat = 1;
    while (!outValid && lat < 100) begin @(posedge clk); #1; lat++; end
    check(name, 64'(lat), 64'(expLat));
  endtask

  task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp, input int lat);
    issue(f, a, b, rd, exp, 1'b1);
    waitDone(name, lat);
    @(posedge clk); #1;
    check("ready_after_handoff", {63'd0, inReady}, 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    arst = 1'b1; inValid = 1'b0; funct3 = 3'd0; operandA = 32'd0; operandB = 32'd0;
    rdAddr = 5'd0; flush = 1'b0; outReady = 1'b1;
    #3;
    check("rst_inReady", {63'd0, inReady}, 64'd1);
    check("rst_outValid", {63'd0, outValid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_outRdAddr", {59'd0, outRdAddr}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); arst = 1'b0;
    @(posedge clk); #1;

    // Multiply
    runOp("lat_mul",    3'b000, 32'hFFFF_FFFF, 32'd7, 5'd5, 32'hFFFF_FFF9, MUL_LAT);
    runOp("lat_mulh",   3'b001, 32'hFFFF_FFFF, 32'd7, 5'd5, 32'hFFFF_FFFF, MUL_LAT);
    runOp("lat_mulhu",  3'b011, 32'hFFFF_FFFF, 32'd7, 5'd5, 32'h0000_0006, MUL_LAT);
    runOp("lat_mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd7, 5'd5, 32'hFFFF_FFFF, MUL_LAT);
    runOp("lat_mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000, MUL_LAT);
    runOp("lat_mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE, MUL_LAT);

    // Divide
    runOp("lat_div",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, DIV_LAT);
    runOp("lat_rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, DIV_LAT);
    runOp("lat_divu", 3'b101, 32'd100, 32'd7, 5'd8, 32'd14, DIV_LAT);
    runOp("lat_remu", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2, DIV_LAT);
    runOp("lat_rem_negneg", 3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd0, 32'hFFFF_FFFF, DIV_LAT);
    runOp("lat_div_min2",   3'b100, 32'h8000_0000, 32'd2, 5'd3, 32'hC000_0000, DIV_LAT);
    runOp("lat_divu_notovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'd0, DIV_LAT);

    // Special cases
    runOp("lat_divu_zero", 3'b101, 32'h0000_1234, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
    runOp("lat_rem_zero",  3'b110, 32'h0000_1234, 32'd0, 5'd11, 32'h0000_1234, 1);
    runOp("lat_div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 1);
    runOp("lat_rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1);

    // Backpressure
    outReady = 1'b0;
    issue(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 1'b1);
    waitDone("lat_backpressure", DIV_LAT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_result", {32'd0, result}, 64'd14);
      check("bp_rd", {59'd0, outRdAddr}, 64'd9);
      check("bp_inReady", {63'd0, inReady}, 64'd0);
      check("bp_outValid", {63'd0, outValid}, 64'd1);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after", {63'd0, inReady}, 64'd1);
    check("bp_valid_after", {63'd0, outValid}, 64'd0);

    // Flush at iteration 10 of a DIV
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_outValid", {63'd0, outValid}, 64'd0);
    check("flush_inReady", {63'd0, inReady}, 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (outValid) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    runOp("lat_mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd2, 32'd12, MUL_LAT);

    // Flush beats a simultaneous request
    inValid = 1'b1; flush = 1'b1; funct3 = 3'b000; operandA = 32'd5; operandB = 32'd5; rdAddr = 5'd1;
    @(posedge clk); #1;
    inValid = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (outValid || !inReady) seen++;
    end
    check("flush_vs_request", 64'(seen), 64'd0);

    // Asynchronous reset mid-CALC
    issue(3'b101, 32'd1000, 32'd3, 5'd17, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #3 arst = 1'b1;
    #1;
    check("arst_outValid", {63'd0, outValid}, 64'd0);
    check("arst_result", {32'd0, result}, 64'd0);
    check("arst_outRdAddr", {59'd0, outRdAddr}, 64'd0);
    check("arst_inReady", {63'd0, inReady}, 64'd1);
    @(negedge clk); arst = 1'b0;
    @(posedge clk); #1;
    runOp("lat_after_arst", 3'b101, 32'd1000, 32'd3, 5'd17, 32'd333, DIV_LAT);

    repeat (3) @(posedge clk);
    check("queue_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
